// File: rtl/debug_clock_controller.sv
// debug_clock_controller
// Sequences the processor debug clock: derives rate ticks from the system
// clock and issues a one-cycle cpu_clk_en pulse in one of four modes
// (HALT, RUN, STEP, BURST). run_sw and step_btn are synchronized, and
// step_btn is also debounced.
// Optional build macro DEBUG_CLK_UART_TICK_EN adds a free-running uart_tick
// output that pulses once every floor(CLK_FREQ/UART_BAUD) cycles.
module debug_clock_controller #(
  parameter int CLK_FREQ        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 32,
  parameter int UART_BAUD       = 9600
) (
`ifdef DEBUG_CLK_UART_TICK_EN
  output logic             uart_tick,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       rate_sel,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             burst_go,
  input  logic [15:0]      burst_len,
  input  logic             halt_req,
  output logic             cpu_clk_en,
  output logic [1:0]       state,
  output logic [1:0]       rate_active,
  output logic [CNT_W-1:0] tick_count
);

  // Baud divisor, clamped so a baud above CLK_FREQ still gives a sane value.
  localparam int UDIV = (UART_BAUD > 0 && (CLK_FREQ / UART_BAUD) > 0) ?
                        (CLK_FREQ / UART_BAUD) : 1;
  // One counter width wide enough for both the rate prescaler and the
  // baud counter.
  localparam int PS_W = $clog2((CLK_FREQ > UDIV) ? CLK_FREQ : UDIV) + 1;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PS_W-1:0] DIV_M1_5HZ  = PS_W'(CLK_FREQ / 5 - 1);
  localparam logic [PS_W-1:0] DIV_M1_1HZ  = PS_W'(CLK_FREQ / 1 - 1);
  localparam logic [PS_W-1:0] DIV_M1_10HZ = PS_W'(CLK_FREQ / 10 - 1);
  localparam logic [PS_W-1:0] DIV_M1_20HZ = PS_W'(CLK_FREQ / 20 - 1);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } state_t;

  logic             run_s1_q, run_s2_q;
  logic             step_s1_q, step_s2_q;
  logic             step_db_q, step_db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             step_req_q, step_req_d;
  logic             step_pend_q, step_pend_d;
  state_t           state_q, state_d;
  logic [1:0]       rate_q, rate_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [15:0]      rem_q, rem_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  div_m1;
  logic             tick;
  logic             step_go;

  // Two-flop synchronizers for the asynchronous switch and button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_s1_q  <= 1'b0;
      run_s2_q  <= 1'b0;
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
    end else begin
      run_s1_q  <= run_sw;
      run_s2_q  <= run_s1_q;
      step_s1_q <= step_btn;
      step_s2_q <= step_s1_q;
    end
  end

  // Debounce: follow the synchronized button only after it has disagreed
  // for DEBOUNCE_CYCLES consecutive cycles; flag the accepted rising edge.
  always_comb begin
    step_db_d = step_db_q;
    db_cnt_d  = '0;
    if (step_s2_q != step_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        step_db_d = step_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    step_req_d = step_db_d & ~step_db_q;
  end

  // Terminal prescaler count for the rate currently applied.
  always_comb begin
    case (rate_q)
      2'b00:   div_m1 = DIV_M1_5HZ;
      2'b01:   div_m1 = DIV_M1_1HZ;
      2'b10:   div_m1 = DIV_M1_10HZ;
      default: div_m1 = DIV_M1_20HZ;
    endcase
  end

  assign tick    = ((state_q == ST_RUN) || (state_q == ST_BURST)) && (ps_q == div_m1);
  assign step_go = step_req_q | step_pend_q;

  // Next-state, prescaler, rate and pulse decisions. The prescaler only
  // advances in RUN/BURST, and a rate change there waits for a tick so no
  // period is ever shortened or stretched.
  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    ps_d        = '0;
    rem_d       = rem_q;
    en_d        = 1'b0;
    step_pend_d = 1'b0;
    cnt_d       = cnt_q + CNT_W'(en_q);
    case (state_q)
      ST_HALT: begin
        rate_d = rate_sel;
        if (!halt_req) begin
          if (burst_go && (burst_len != 16'd0)) begin
            state_d = ST_BURST;
            rem_d   = burst_len;
          end else if (step_go) begin
            // A step landing right after a burst's last pulse waits one
            // cycle so the enable never fires twice in a row.
            if (en_q) begin
              step_pend_d = 1'b1;
            end else begin
              state_d = ST_STEP;
              en_d    = 1'b1;
            end
          end else if (run_s2_q) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_STEP: begin
        rate_d  = rate_sel;
        state_d = ST_HALT;
      end
      ST_RUN: begin
        if (halt_req || !run_s2_q) begin
          state_d = ST_HALT;
        end else if (tick) begin
          en_d   = 1'b1;
          rate_d = rate_sel;
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end
      ST_BURST: begin
        if (halt_req) begin
          state_d = ST_HALT;
          rem_d   = 16'd0;
        end else if (tick) begin
          en_d   = 1'b1;
          rate_d = rate_sel;
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = ST_HALT;
          end
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_db_q   <= 1'b0;
      db_cnt_q    <= '0;
      step_req_q  <= 1'b0;
      step_pend_q <= 1'b0;
      state_q     <= ST_HALT;
      rate_q      <= 2'b00;
      ps_q        <= '0;
      rem_q       <= 16'd0;
      en_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      step_db_q   <= step_db_d;
      db_cnt_q    <= db_cnt_d;
      step_req_q  <= step_req_d;
      step_pend_q <= step_pend_d;
      state_q     <= state_d;
      rate_q      <= rate_d;
      ps_q        <= ps_d;
      rem_q       <= rem_d;
      en_q        <= en_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_clk_en  = en_q;
  assign state       = state_q;
  assign rate_active = rate_q;
  assign tick_count  = cnt_q;

`ifdef DEBUG_CLK_UART_TICK_EN
  localparam logic [PS_W-1:0] UDIV_M1 = PS_W'(UDIV - 1);

  logic [PS_W-1:0] ucnt_q, ucnt_d;
  logic            uart_tick_q, uart_tick_d;

  // Free-running baud counter, independent of the sequencer state.
  always_comb begin
    uart_tick_d = (ucnt_q == UDIV_M1);
    ucnt_d      = uart_tick_d ? '0 : (ucnt_q + PS_W'(1));
  end

  // Baud counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ucnt_q      <= '0;
      uart_tick_q <= 1'b0;
    end else begin
      ucnt_q      <= ucnt_d;
      uart_tick_q <= uart_tick_d;
    end
  end

  assign uart_tick = uart_tick_q;
`endif

endmodule

// File: tb/tb_debug_clock_controller.sv
// Testbench for debug_clock_controller: directed scenarios followed by
// randomized stimulus, all compared against a cycle-scheduled reference model.
module tb_debug_clock_controller;

  localparam int CLK_FREQ  = 200;
  localparam int DEB       = 4;
  localparam int CNT_W     = 6;
  localparam int UART_BAUD = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       rate_sel = 2'b00;
  logic             run_sw = 1'b0;
  logic             step_btn = 1'b0;
  logic             burst_go = 1'b0;
  logic [15:0]      burst_len = 16'd0;
  logic             halt_req = 1'b0;
  logic             cpu_clk_en;
  logic [1:0]       state;
  logic [1:0]       rate_active;
  logic [CNT_W-1:0] tick_count;
`ifdef DEBUG_CLK_UART_TICK_EN
  logic             uart_tick;
  longint           last_uart = -1;
`endif

  debug_clock_controller #(
    .CLK_FREQ(CLK_FREQ),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W),
    .UART_BAUD(UART_BAUD)
  ) dut (
`ifdef DEBUG_CLK_UART_TICK_EN
    .uart_tick(uart_tick),
`endif
    .clk(clk),
    .reset(reset),
    .rate_sel(rate_sel),
    .run_sw(run_sw),
    .step_btn(step_btn),
    .burst_go(burst_go),
    .burst_len(burst_len),
    .halt_req(halt_req),
    .cpu_clk_en(cpu_clk_en),
    .state(state),
    .rate_active(rate_active),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint ecount  = 0;   // posedges seen
  int     pulses  = 0;   // cpu_clk_en pulses observed
  int     steps   = 0;   // cycles observed in STEP
  logic   prev_en = 1'b0;

  // Reference model state: pulses are scheduled at absolute edge numbers.
  int     m_state, m_rate, m_rem, m_en, m_cnt, m_req, m_pend, m_db;
  longint m_due;
  bit     raw_run[$];
  bit     raw_step[$];
  bit     sync_step[$];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, ecount);
    end
  endtask

  function automatic int div_of(input int r);
    int hz;
    case (r)
      0:       hz = 5;
      1:       hz = 1;
      2:       hz = 10;
      default: hz = 20;
    endcase
    return CLK_FREQ / hz;
  endfunction

  task automatic model_reset();
    m_state = 0; m_rate = 0; m_rem = 0; m_en = 0; m_cnt = 0;
    m_req = 0; m_pend = 0; m_db = 0; m_due = 0;
    raw_run.delete(); raw_step.delete(); sync_step.delete();
  endtask

  // One clock edge of the behavioural model, using inputs as held at the edge.
  task automatic model_step();
    bit run_s, st_s, all_diff, new_req, tick;
    int ns, nr, nrem, nen, npend;
    run_s = (raw_run.size() >= 2) ? raw_run[raw_run.size()-2] : 1'b0;
    st_s  = (raw_step.size() >= 2) ? raw_step[raw_step.size()-2] : 1'b0;
    raw_run.push_back(run_sw);
    raw_step.push_back(step_btn);
    while (raw_run.size() > 4) void'(raw_run.pop_front());
    while (raw_step.size() > 4) void'(raw_step.pop_front());

    // Debounce: accept a new level once the last DEB synced samples all disagree.
    new_req = 0;
    sync_step.push_back(st_s);
    while (sync_step.size() > DEB) void'(sync_step.pop_front());
    if (sync_step.size() == DEB) begin
      all_diff = 1;
      foreach (sync_step[i]) if (sync_step[i] == m_db[0]) all_diff = 0;
      if (all_diff) begin
        m_db = st_s;
        new_req = st_s;
      end
    end

    tick  = (m_state == 1 || m_state == 3) && (ecount == m_due);
    ns    = m_state; nr = m_rate; nrem = m_rem; nen = 0; npend = 0;
    case (m_state)
      0: begin
        nr = rate_sel;
        if (!halt_req) begin
          if (burst_go && burst_len != 0) begin
            ns = 3; nrem = burst_len; m_due = ecount + div_of(rate_sel);
          end else if (m_req || m_pend) begin
            if (m_en) npend = 1;
            else begin ns = 2; nen = 1; end
          end else if (run_s) begin
            ns = 1; m_due = ecount + div_of(rate_sel);
          end
        end
      end
      2: begin nr = rate_sel; ns = 0; end
      1: begin
        if (halt_req || !run_s) ns = 0;
        else if (tick) begin nen = 1; nr = rate_sel; m_due = ecount + div_of(rate_sel); end
      end
      default: begin
        if (halt_req) begin ns = 0; nrem = 0; end
        else if (tick) begin
          nen = 1; nr = rate_sel; nrem = m_rem - 1;
          m_due = ecount + div_of(rate_sel);
          if (nrem == 0) ns = 0;
        end
      end
    endcase
    m_cnt   = (m_cnt + m_en) % (1 << CNT_W);
    m_state = ns; m_rate = nr; m_rem = nrem; m_en = nen;
    m_pend  = npend; m_req = new_req;
  endtask

  // Advance one clock, update the model on the edge, compare on the falling edge.
  task automatic tick_cycle();
    @(posedge clk);
    ecount++;
    if (!reset) model_reset();
    else model_step();
    @(negedge clk);
    check_val("state", state, m_state);
    check_val("cpu_clk_en", cpu_clk_en, m_en);
    check_val("rate_active", rate_active, m_rate);
    check_val("tick_count", tick_count, m_cnt);
    check_val("en_back_to_back", cpu_clk_en & prev_en, 0);
    prev_en = cpu_clk_en;
    if (cpu_clk_en) pulses++;
    if (state == 2'b10) steps++;
`ifdef DEBUG_CLK_UART_TICK_EN
    if (!reset) last_uart = -1;
    else if (uart_tick) begin
      if (last_uart >= 0) check_val("uart_period", ecount - last_uart, CLK_FREQ / UART_BAUD);
      last_uart = ecount;
    end
`endif
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check_val("arst_state", state, 0);
    check_val("arst_en", cpu_clk_en, 0);
    check_val("arst_rate", rate_active, 0);
    check_val("arst_count", tick_count, 0);
    model_reset();
    prev_en = 1'b0;
    run_cycles(2);
    reset = 1'b1;
  endtask

  initial begin
    int p0, c0, s0;
    bit st_tgt;
    bit bounce[8];
    model_reset();
    #1 reset = 1'b0;
    #1;
    check_val("reset_state", state, 0);
    check_val("reset_en", cpu_clk_en, 0);
    check_val("reset_rate", rate_active, 0);
    check_val("reset_count", tick_count, 0);
    run_cycles(2);
    reset = 1'b1;
    run_cycles(2);

    // Free run at 5 Hz.
    run_sw = 1'b1; rate_sel = 2'b00;
    run_cycles(3);
    check_val("tp1_enter_run", state, 1);
    p0 = pulses;
    run_cycles(207);
    check_val("tp1_pulses", pulses - p0, 5);
    check_val("tp1_count", tick_count, 5);

    // Rate change mid-period takes effect at the next tick.
    rate_sel = 2'b11;
    run_cycles(36);
    check_val("tp2_rate_applied", rate_active, 3);
    p0 = pulses;
    run_cycles(40);
    check_val("tp2_fast_pulses", pulses - p0, 4);

    // Bouncy single step from HALT.
    run_sw = 1'b0;
    run_cycles(4);
    check_val("tp3_halt", state, 0);
    p0 = pulses; c0 = tick_count; s0 = steps;
    bounce = '{1, 0, 1, 1, 0, 0, 1, 0};
    foreach (bounce[i]) begin step_btn = bounce[i]; tick_cycle(); end
    step_btn = 1'b1; run_cycles(10);
    step_btn = 1'b0; run_cycles(10);
    check_val("tp3_pulses", pulses - p0, 1);
    check_val("tp3_step_cycles", steps - s0, 1);
    check_val("tp3_count", (tick_count - c0) % (1 << CNT_W), 1);
    check_val("tp3_back_halt", state, 0);

    // Burst of three at 10 Hz, then a zero-length request.
    rate_sel = 2'b10; run_cycles(2);
    p0 = pulses;
    burst_go = 1'b1; burst_len = 16'd3; tick_cycle();
    burst_go = 1'b0;
    check_val("tp4_burst", state, 3);
    run_cycles(65);
    check_val("tp4_pulses", pulses - p0, 3);
    check_val("tp4_done", state, 0);
    burst_go = 1'b1; burst_len = 16'd0; tick_cycle();
    burst_go = 1'b0;
    check_val("tp4_len0_ignored", state, 0);

    // halt_req on the second tick edge of a burst of five.
    p0 = pulses;
    burst_go = 1'b1; burst_len = 16'd5; tick_cycle();
    burst_go = 1'b0;
    run_cycles(39);
    halt_req = 1'b1; tick_cycle();
    halt_req = 1'b0;
    run_cycles(30);
    check_val("tp5_pulses", pulses - p0, 1);
    check_val("tp5_halted", state, 0);

    // Asynchronous reset mid-run.
    run_sw = 1'b1; run_cycles(50);
    async_reset();
    run_sw = 1'b0; run_cycles(5);

    // Randomized stimulus.
    st_tgt = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 299) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 149) == 0) rate_sel = 2'($urandom_range(0, 3));
      halt_req = ($urandom_range(0, 199) == 0);
      burst_go = ($urandom_range(0, 79) == 0);
      burst_len = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 59) == 0) st_tgt = ~st_tgt;
      step_btn = ($urandom_range(0, 5) == 0) ? ~st_tgt : st_tgt;
      if ($urandom_range(0, 3999) == 0) async_reset();
      tick_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_clock_controller.md
Name: debug_clock_controller

Overview:
Sequences the processor debug clock. It derives rate ticks from the system clock and runs the CPU clock-enable in one of four modes: free run, halt, single step, or counted burst. It sits between the board clock/buttons and the MIPS core, replacing the open-loop 1/5/10/20 Hz clock mux with a glitch-free, controllable enable.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz; must be >= 40.
DEBOUNCE_CYCLES, 500000, clk cycles step_btn must be stable before it is accepted.
CNT_W, 32, width of tick_count.
UART_BAUD, 9600, baud tick rate, used only with the optional feature.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rate_sel  in  2  requested rate: 00=5 Hz, 01=1 Hz, 10=10 Hz, 11=20 Hz
run_sw  in  1  run switch, asynchronous; level-sensitive
step_btn  in  1  single-step push button, asynchronous, bouncy
burst_go  in  1  synchronous 1-cycle request to start a burst
burst_len  in  16  number of enables in a burst, sampled on burst_go
halt_req  in  1  synchronous halt request, e.g. from a breakpoint
cpu_clk_en  out  1  one-clk-wide enable pulse to the core
state  out  2  00=HALT, 01=RUN, 10=STEP, 11=BURST
rate_active  out  2  rate currently applied
tick_count  out  CNT_W  total cpu_clk_en pulses issued

Behaviour:
- Reset (reset=0, asynchronous): all registers are cleared.
  - state=HALT, rate_active=00, prescaler=0, remaining=0.
  - cpu_clk_en=0, tick_count=0.
  - Synchronizer and debounce registers are cleared.
- Reset asserted mid-burst or mid-step aborts immediately. No pulse is issued after reset releases until a new request arrives.
- Input conditioning:
  - run_sw passes through a 2-FF synchronizer.
  - step_btn passes through a 2-FF synchronizer, then a debouncer: the debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - step_req is a 1-cycle pulse on the debounced rising edge.
- Divisor: DIV = floor(CLK_FREQ / f) for the active rate f.
  - The prescaler counts 0..DIV-1; tick=1 when prescaler==DIV-1, then the prescaler reloads 0.
  - The prescaler is held at 0 in HALT and STEP and counts only in RUN and BURST.
  - The first pulse therefore occurs DIV cycles after entering RUN or BURST.
- Rate change:
  - In HALT or STEP: rate_active <= rate_sel on the next edge.
  - In RUN or BURST: the new rate is applied only on a tick edge, and the prescaler restarts at 0. No shortened or double period is ever produced.
- State machine (registered; outputs registered on the same edge):
  - HALT:
    - halt_req: stay in HALT.
    - else burst_go with burst_len!=0: go to BURST, remaining <= burst_len.
    - else step_req: go to STEP.
    - else run_sw: go to RUN.
    - burst_go with burst_len==0 is ignored.
  - STEP: lasts exactly one cycle. cpu_clk_en=1 in that cycle, then HALT.
  - RUN:
    - cpu_clk_en=1 in the cycle after each tick edge.
    - halt_req or run_sw=0 goes to HALT on the next edge. A tick on that same edge is suppressed.
    - step_req and burst_go are ignored.
  - BURST:
    - Each tick issues a pulse and decrements remaining.
    - The tick that takes remaining from 1 to 0 issues its pulse and moves to HALT.
    - halt_req aborts to HALT with no further pulse; halt_req wins over a simultaneous tick.
    - run_sw, step_req and burst_go are ignored.
- cpu_clk_en is never high for two consecutive cycles.
- tick_count increments on every cycle with cpu_clk_en=1 and wraps modulo 2^CNT_W.

Optional Feature:
DEBUG_CLK_UART_TICK_EN
- Defined:
  - Adds output uart_tick (1 bit), a free-running 1-cycle pulse every floor(CLK_FREQ/UART_BAUD) cycles.
  - It is independent of state and cleared by reset.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
Use CLK_FREQ=200 (DIV: 1 Hz=200, 5 Hz=40, 10 Hz=20, 20 Hz=10) and DEBOUNCE_CYCLES=4.
1. Release reset, set run_sw=1 with rate_sel=00 -> state=RUN within 3 cycles; cpu_clk_en pulses every 40 cycles; tick_count=5 after 5 pulses.
2. In RUN, switch rate_sel 00->11 mid-period -> the current 40-cycle period completes, rate_active=11 at that tick, then pulses every 10 cycles; no interval below 10 or between 10 and 40.
3. In HALT, bounce step_btn (1-2 cycle glitches), then hold it high for 10 cycles -> exactly one STEP cycle, one cpu_clk_en pulse, tick_count+1, return to HALT.
4. In HALT at rate 10 Hz, burst_go with burst_len=3 -> three pulses at 20-cycle spacing, then HALT; tick_count+3. Repeat with burst_len=0 -> no state change.
5. In BURST with burst_len=5, assert halt_req on the same edge as the 2nd tick -> HALT with only 1 pulse issued.
6. Assert reset low asynchronously mid-RUN, between clk edges -> all outputs 0 and state=HALT immediately. With DEBUG_CLK_UART_TICK_EN and UART_BAUD=20, uart_tick pulses every 10 cycles regardless of state.
